// File: rtl/line_hit_monitor.sv
// line_hit_monitor
// Watches the player cube against a horizontal line once per video frame.
// Overlap between cube and solid line pixels is accumulated into sticky
// per-frame flags; at each end-of-frame strobe the FSM decides whether the
// overlap has persisted for CONFIRM_FRAMES consecutive frames and latches a
// crash. Optional pass detection and the saturating score counter are built
// only when the macro LINE_HIT_SCORE_EN is defined; otherwise pass and score
// are tied to zero and no scoring registers exist.
module line_hit_monitor #(
    parameter int CONFIRM_FRAMES = 2,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame,
    input  logic               active,
    input  logic               freeze,
    input  logic               clear,
    input  logic               cube,
    input  logic               h_line,
    input  logic               line_row,
    output logic               crash,
    output logic               crash_pulse,
    output logic               pass,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        CONFIRM = 2'd2,
        CRASH   = 2'd3
    } state_t;

    localparam logic [2:0] CONFIRM_CNT = 3'(CONFIRM_FRAMES);

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       ovl_q, ovl_d;
    logic       ovl_now;
    logic       crash_pulse_q, crash_pulse_d;
    logic       frame_frozen;
    logic       frame_eval;

    // The frame cycle's own pixel sample must take part in that frame's decision.
    assign ovl_now      = ovl_q | (cube & h_line);
    assign frame_frozen = frame & freeze;
    // A frame strobe that actually drives the watch/confirm decision.
    assign frame_eval   = frame & ~freeze & ~clear & active &
                          ((state_q == WATCH) || (state_q == CONFIRM));

    // State and confirm-count register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state: clear wins, a frozen frame holds, active=0 drops out of the watch states.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (frame_frozen) begin
            state_d = state_q;
            count_d = count_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (active) begin
                        state_d = WATCH;
                    end
                end
                WATCH: begin
                    if (!active) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (frame && ovl_now) begin
                        count_d = 3'd1;
                        state_d = (CONFIRM_CNT == 3'd1) ? CRASH : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!active) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (frame) begin
                        if (ovl_now) begin
                            count_d = count_q + 3'd1;
                            if ((count_q + 3'd1) == CONFIRM_CNT) begin
                                state_d = CRASH;
                            end
                        end else begin
                            state_d = WATCH;
                            count_d = '0;
                        end
                    end
                end
                CRASH: begin
                    state_d = CRASH;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        state       = state_q;
        crash       = (state_q == CRASH);
        crash_pulse = crash_pulse_q;
    end

    // Overlap flag and crash-entry pulse next values.
    always_comb begin
        ovl_d         = (clear || frame) ? 1'b0 : ovl_now;
        crash_pulse_d = (state_d == CRASH) && (state_q != CRASH);
    end

    // Overlap flag and crash-entry pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovl_q         <= 1'b0;
            crash_pulse_q <= 1'b0;
        end else begin
            ovl_q         <= ovl_d;
            crash_pulse_q <= crash_pulse_d;
        end
    end

`ifdef LINE_HIT_SCORE_EN
    logic               row_q, row_d;
    logic               row_now;
    logic               row_prev_q, row_prev_d;
    logic               pass_q, pass_d;
    logic [SCORE_W-1:0] score_q, score_d;

    assign row_now = row_q | (cube & line_row);

    // Pass detection: cube sat in the line band last frame, is clear of it now, never touched the line.
    always_comb begin
        row_d      = (clear || frame) ? 1'b0 : row_now;
        row_prev_d = row_prev_q;
        score_d    = score_q;
        pass_d     = 1'b0;
        if (clear) begin
            row_prev_d = 1'b0;
            score_d    = '0;
        end else if (frame_eval) begin
            row_prev_d = row_now;
            if ((state_q == WATCH) && row_prev_q && !row_now && !ovl_now) begin
                pass_d = 1'b1;
                if (score_q != '1) begin
                    score_d = score_q + SCORE_W'(1);
                end
            end
        end
    end

    // Scoring registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_q      <= 1'b0;
            row_prev_q <= 1'b0;
            pass_q     <= 1'b0;
            score_q    <= '0;
        end else begin
            row_q      <= row_d;
            row_prev_q <= row_prev_d;
            pass_q     <= pass_d;
            score_q    <= score_d;
        end
    end

    assign pass  = pass_q;
    assign score = score_q;
`else
    // Band input only matters for scoring; kept visible but intentionally unused here.
    logic unused_line_row;
    assign unused_line_row = line_row;
    assign pass            = 1'b0;
    assign score           = '0;
`endif

endmodule

// File: tb/tb_line_hit_monitor.sv
// Self-checking bench for line_hit_monitor: a per-cycle vector table for the
// crash/freeze/clear/reset corner cases, a hand sequence for passes and score
// saturation, then randomized stimulus against a frame-level reference model.
module tb_line_hit_monitor;

    localparam int CF = 2;
    localparam int SW = 8;
    localparam int SCORE_MAX = (1 << SW) - 1;

    localparam int S_IDLE    = 0;
    localparam int S_WATCH   = 1;
    localparam int S_CONFIRM = 2;
    localparam int S_CRASH   = 3;

`ifdef LINE_HIT_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, frame, active, freeze, clear, cube, h_line, line_row;
    logic          crash, crash_pulse, pass;
    logic [SW-1:0] score;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_hit_monitor #(.CONFIRM_FRAMES(CF), .SCORE_W(SW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame      (frame),
        .active     (active),
        .freeze     (freeze),
        .clear      (clear),
        .cube       (cube),
        .h_line     (h_line),
        .line_row   (line_row),
        .crash      (crash),
        .crash_pulse(crash_pulse),
        .pass       (pass),
        .score      (score),
        .state      (state)
    );

    // Reference model: frame-level game rules tracked with plain integers.
    int m_state   = S_IDLE;
    int m_streak  = 0;
    int m_score   = 0;
    bit m_rowprev = 1'b0;
    bit m_ovl     = 1'b0;
    bit m_row     = 1'b0;
    bit m_pass    = 1'b0;
    bit m_pulse   = 1'b0;

    task automatic model_zero();
        m_state   = S_IDLE;
        m_streak  = 0;
        m_score   = 0;
        m_rowprev = 1'b0;
        m_ovl     = 1'b0;
        m_row     = 1'b0;
    endtask

    task automatic model_edge();
        bit o, r;
        int prev;
        o      = m_ovl | (cube & h_line);
        r      = m_row | (cube & line_row);
        prev   = m_state;
        m_pass = 1'b0;
        if (!reset_n || clear) begin
            model_zero();
        end else begin
            if (!(frame && freeze)) begin
                if (m_state == S_IDLE) begin
                    if (active) m_state = S_WATCH;
                end else if (m_state != S_CRASH) begin
                    if (!active) begin
                        m_state  = S_IDLE;
                        m_streak = 0;
                    end else if (frame) begin
                        if (o) begin
                            m_streak = m_streak + 1;
                            m_state  = (m_streak >= CF) ? S_CRASH : S_CONFIRM;
                        end else begin
                            if (m_state == S_WATCH && m_rowprev && !r) begin
                                m_pass  = 1'b1;
                                m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                            end
                            m_streak = 0;
                            m_state  = S_WATCH;
                        end
                        m_rowprev = r;
                    end
                end
            end
            if (frame) begin
                m_ovl = 1'b0;
                m_row = 1'b0;
            end else begin
                m_ovl = o;
                m_row = r;
            end
        end
        m_pulse = (m_state == S_CRASH) && (prev != S_CRASH);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".crash"}, int'(crash), int'(m_state == S_CRASH));
        chk({tag, ".crash_pulse"}, int'(crash_pulse), int'(m_pulse));
        chk({tag, ".pass"}, int'(pass), SCORE_ON ? int'(m_pass) : 0);
        chk({tag, ".score"}, int'(score), SCORE_ON ? m_score : 0);
    endtask

    // Drive one clock of inputs, advance the model on the edge, sample 1 time unit later.
    task automatic drive(input logic rn, input logic a, input logic fz, input logic cl,
                         input logic fr, input logic cb, input logic hl, input logic lr);
        reset_n  = rn;
        active   = a;
        freeze   = fz;
        clear    = cl;
        frame    = fr;
        cube     = cb;
        h_line   = hl;
        line_row = lr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       rn, a, fz, cl, fr, cb, hl, lr;
        logic [1:0] st;
        logic       cr, cp;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic a, input logic fz, input logic cl,
                                input logic fr, input logic cb, input logic hl, input logic lr,
                                input logic [1:0] st, input logic cr, input logic cp);
        vec_t v;
        v.rn = rn; v.a = a; v.fz = fz; v.cl = cl; v.fr = fr;
        v.cb = cb; v.hl = hl; v.lr = lr;
        v.st = st; v.cr = cr; v.cp = cp;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0; active = 1'b0; freeze = 1'b0; clear = 1'b0;
        frame = 1'b0; cube = 1'b0; h_line = 1'b0; line_row = 1'b0;

        //            rn a  fz cl fr cb hl lr   state    cr cp
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0)); // reset
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0)); // IDLE->WATCH
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd2, 0, 0)); // overlap on frame cycle
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 0)); // single frame only -> WATCH
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 2'd1, 0, 0)); // overlap mid-frame (sticky)
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'd2, 0, 0)); // sticky flag seen at strobe
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd3, 1, 1)); // 2nd frame -> CRASH, pulse
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd3, 1, 0)); // crash holds, active=0
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 2'd3, 1, 0)); // frame ignored in CRASH
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0)); // clear+frame -> IDLE
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 2'd1, 0, 0)); // frozen overlap frame
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 0)); // following clean frame
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 2'd0, 0, 0)); // reset in CONFIRM
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd1, 0, 0)); // frame in IDLE: no eval
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'd1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0)); // active=0 -> IDLE
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 2'd0, 0, 0)); // active=0 beats frame
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 2'd3, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'd3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0, 0)); // reset in CRASH
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rn, tbl[i].a, tbl[i].fz, tbl[i].cl, tbl[i].fr,
                  tbl[i].cb, tbl[i].hl, tbl[i].lr);
            chk($sformatf("vec%0d.state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("vec%0d.crash", i), int'(crash), int'(tbl[i].cr));
            chk($sformatf("vec%0d.crash_pulse", i), int'(crash_pulse), int'(tbl[i].cp));
            chk($sformatf("vec%0d.pass", i), int'(pass), 0);
            chk($sformatf("vec%0d.score", i), int'(score), 0);
        end

        // Pass: cube in the band (no line) in frame N, absent in frame N+1.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0, 1);
        chk("pass_n.pass", int'(pass), 0);
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        chk("pass_n1.pass", int'(pass), SCORE_ON ? 1 : 0);
        chk("pass_n1.score", int'(score), SCORE_ON ? 1 : 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("pass_after.pass", int'(pass), 0);
        chk("pass_after.score", int'(score), SCORE_ON ? 1 : 0);

        // Saturation: 299 more passes, 300 total.
        for (int unsigned i = 0; i < 299; i++) begin
            drive(1, 1, 0, 0, 1, 1, 0, 1);
            drive(1, 1, 0, 0, 1, 0, 0, 0);
            chk_model($sformatf("sat%0d", i));
        end
        chk("sat_final.score", int'(score), SCORE_ON ? SCORE_MAX : 0);
        chk("sat_final.state", int'(state), S_WATCH);

        // Randomized stimulus against the reference model.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_model("rnd_reset");
        for (int unsigned i = 0; i < 4000; i++) begin
            logic rn, a, fz, cl, fr, cb, hl, lr;
            rn = ($urandom_range(63) != 0);
            a  = ($urandom_range(7) != 0);
            fz = ($urandom_range(7) == 0);
            cl = ($urandom_range(47) == 0);
            fr = ($urandom_range(3) == 0);
            cb = $urandom_range(1);
            hl = ($urandom_range(2) == 0);
            lr = hl | ($urandom_range(1) == 1);
            drive(rn, a, fz, cl, fr, cb, hl, lr);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
